// File: rtl/novacore_cfg_pkg.sv
// Purpose: shared loader constants (bus/uid default widths, frame byte counts) and FSM encoding.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package novacore_cfg_pkg;

  localparam int DEF_BUS_W   = 82;
  localparam int DEF_UID_W   = 9;
  localparam int HDR_BYTES   = 2;
  localparam int PAY_BYTES   = 11;
  localparam int FRAME_BYTES = HDR_BYTES + PAY_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_SETUP,
    ST_CLK_HI,
    ST_CLK_LO
  } cfg_state_t;

endpackage

// File: rtl/cfg_frame_assembler.sv
// Purpose: assembles one frame (2 header bytes + 11 payload bytes, MSB first) into uid and config word.
// Latency: o_word/o_pay_last are combinational with the last payload byte; o_uid is registered.
// Backpressure: none internally; only shifts when i_xfer (valid && ready) is high.
//
// Ports: clk/rst clock and async reset; i_clr holds the byte counter at frame start;
//   i_xfer/i_byte accepted byte; o_hdr_last/o_pay_last flag the last header/payload byte
//   in the transfer cycle; o_uid header target id; o_word config word including the current byte.
module cfg_frame_assembler
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W = DEF_BUS_W,
  parameter int UID_W = DEF_UID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_xfer,
  input  logic [7:0]       i_byte,
  output logic             o_hdr_last,
  output logic             o_pay_last,
  output logic [UID_W-1:0] o_uid,
  output logic [BUS_W-1:0] o_word
);

  localparam int CNT_W = $clog2(FRAME_BYTES);

  logic [CNT_W-1:0] r_cnt;
  logic [UID_W-1:0] r_uid;
  logic [BUS_W-1:0] r_shift;
  logic             w_in_hdr;

  assign w_in_hdr   = (r_cnt < CNT_W'(HDR_BYTES));
  assign o_hdr_last = i_xfer && (r_cnt == CNT_W'(HDR_BYTES - 1));
  assign o_pay_last = i_xfer && (r_cnt == CNT_W'(FRAME_BYTES - 1));
  assign o_uid      = r_uid;

  // Only the low BUS_W bits of the 88-bit payload are ever observable, so the
  // upper payload bits are simply shifted out. Exposing the word including the
  // byte in flight lets the loader capture it on the same edge it enters SETUP.
  assign o_word = BUS_W'({r_shift, i_byte});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_uid   <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_xfer) begin
      r_cnt <= o_pay_last ? '0 : r_cnt + CNT_W'(1);
      if (w_in_hdr) begin
        // Two header bytes fully replace the id (UID_W <= 16), unused upper bits fall off.
        r_uid <= UID_W'({r_uid, i_byte});
      end else begin
        r_shift <= o_word;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Purpose: streams configuration frames from a byte interface into the fabric and strobes each via c_clk.
// Latency: last payload byte accepted in cycle N -> c_clk rises in cycle N+2, held CCLK_HALF cycles.
// Backpressure: in_ready high only while collecting header/payload; in_valid low stalls indefinitely.
//
// Ports: clk/rst clock and async active-high reset; start begins a load; in_data/in_valid/in_ready
//   byte stream; mode 1 while configuring; c_bus/c_uid/c_clk fabric config word, target and strobe;
//   busy load active; done pulse after the final strobe; err sticky out-of-range uid flag.
module config_loader
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W      = DEF_BUS_W,
  parameter int UID_W      = DEF_UID_W,
  parameter int NUM_FRAMES = 100,
  parameter int CCLK_HALF  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mode,
  output logic [BUS_W-1:0] c_bus,
  output logic [UID_W-1:0] c_uid,
  output logic             c_clk,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int FCNT_W = $clog2(NUM_FRAMES + 1);
  localparam int HALF_W = $clog2(CCLK_HALF + 1);

  cfg_state_t        r_state;
  cfg_state_t        w_next;
  logic [FCNT_W-1:0] r_frames;
  logic [HALF_W-1:0] r_half;
  logic              r_mode;
  logic              r_cclk;
  logic              r_done;
  logic              r_err;
  logic [BUS_W-1:0]  r_bus;
  logic [UID_W-1:0]  r_uid;

  logic              w_in_ready;
  logic              w_xfer;
  logic              w_hdr_last;
  logic              w_pay_last;
  logic [UID_W-1:0]  w_asm_uid;
  logic [BUS_W-1:0]  w_asm_word;
  logic              w_uid_bad;
  logic              w_half_end;
  logic              w_last_frame;
  logic              w_start_acc;
  logic              w_load;
  logic              w_err_set;
  logic              w_frame_end;

  assign w_in_ready   = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
  assign w_xfer       = in_valid && w_in_ready;
  assign w_uid_bad    = (32'(w_asm_uid) >= 32'(NUM_FRAMES));
  assign w_half_end   = (r_half == HALF_W'(CCLK_HALF - 1));
  assign w_last_frame = (r_frames == FCNT_W'(NUM_FRAMES - 1));
  assign w_start_acc  = (r_state == ST_IDLE) && start;

  cfg_frame_assembler #(
    .BUS_W (BUS_W),
    .UID_W (UID_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == ST_IDLE),
    .i_xfer     (w_xfer),
    .i_byte     (in_data),
    .o_hdr_last (w_hdr_last),
    .o_pay_last (w_pay_last),
    .o_uid      (w_asm_uid),
    .o_word     (w_asm_word)
  );

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_HDR;
      ST_HDR:     if (w_hdr_last) w_next = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (w_pay_last) begin
          if (w_uid_bad) begin
            // Out-of-range target: drop the frame without touching the fabric.
            w_err_set = 1'b1;
            w_next    = ST_HDR;
          end else begin
            w_load = 1'b1;
            w_next = ST_SETUP;
          end
        end
      end
      ST_SETUP:   w_next = ST_CLK_HI;
      ST_CLK_HI:  if (w_half_end) w_next = ST_CLK_LO;
      ST_CLK_LO: begin
        if (w_half_end) begin
          w_frame_end = 1'b1;
          w_next      = w_last_frame ? ST_IDLE : ST_HDR;
        end
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_frames <= '0;
      r_half   <= '0;
      r_mode   <= 1'b0;
      r_cclk   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_bus    <= '0;
      r_uid    <= '0;
    end else begin
      r_state <= w_next;
      // Registered from the next state so the strobe is glitch-free and lines up with CLK_HI.
      r_cclk  <= (w_next == ST_CLK_HI);
      r_done  <= w_frame_end && w_last_frame;

      if (w_start_acc) begin
        r_mode   <= 1'b1;
        r_frames <= '0;
        r_err    <= 1'b0;
      end

      if (w_err_set) r_err <= 1'b1;

      if (w_load) begin
        r_bus <= w_asm_word;
        r_uid <= w_asm_uid;
      end

      if (((r_state == ST_CLK_HI) || (r_state == ST_CLK_LO)) && !w_half_end) begin
        r_half <= r_half + HALF_W'(1);
      end else begin
        r_half <= '0;
      end

      if (w_frame_end) begin
        r_frames <= r_frames + FCNT_W'(1);
        if (w_last_frame) r_mode <= 1'b0;
      end
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = (r_state != ST_IDLE);
  assign mode     = r_mode;
  assign c_bus    = r_bus;
  assign c_uid    = r_uid;
  assign c_clk    = r_cclk;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int BUS_W      = 82;
  localparam int UID_W      = 9;
  localparam int NUM_FRAMES = 100;
  localparam int CCLK_HALF  = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [BUS_W-1:0] c_bus;
  logic [UID_W-1:0] c_uid;
  logic             c_clk;
  logic             busy;
  logic             done;
  logic             err;

  typedef struct packed {
    logic [UID_W-1:0] uid;
    logic [BUS_W-1:0] bus;
  } exp_t;

  exp_t             exp_q[$];
  int               n_err     = 0;
  int               n_chk     = 0;
  int               cyc       = 0;
  int               last_acc  = 0;
  int               rise_cyc  = 0;
  int               pulses    = 0;
  int               dones     = 0;
  int               hi_cnt    = 0;
  logic             prev_cclk = 1'b0;
  logic             prev_mode = 1'b0;
  logic [BUS_W-1:0] bus_rise  = '0;
  logic [87:0]      pays [NUM_FRAMES];

  config_loader #(
    .BUS_W      (BUS_W),
    .UID_W      (UID_W),
    .NUM_FRAMES (NUM_FRAMES),
    .CCLK_HALF  (CCLK_HALF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .c_bus    (c_bus),
    .c_uid    (c_uid),
    .c_clk    (c_clk),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (c_clk && !prev_cclk) begin
      rise_cyc = cyc;
      hi_cnt   = 1;
      bus_rise = c_bus;
      pulses++;
      chk("strobe_latency", rise_cyc - last_acc, 1);
      chk("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_c_uid", c_uid, e.uid);
        chk("sb_c_bus", c_bus, e.bus);
      end
    end else if (c_clk) begin
      hi_cnt++;
    end else if (prev_cclk) begin
      chk("cclk_high_cycles", hi_cnt, CCLK_HALF);
      chk("c_bus_stable_in_pulse", c_bus, bus_rise);
    end
    if (done) begin
      dones++;
      chk("mode_low_at_done", mode, 0);
      chk("mode_high_before_done", prev_mode, 1);
    end
    prev_cclk = c_clk;
    prev_mode = mode;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] frame_uid(input int i);
    if (i == 0) return 16'h0005;
    else if (i <= 5) return 16'(i - 1);
    else return 16'(i);
  endfunction

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard;
    guard = 0;
    if (rnd && ($urandom_range(1, 0) == 1)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("byte_accept", in_ready, 1);
    last_acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] uid, input logic [87:0] pay, input bit rnd, input bit push);
    exp_t e;
    if (push) begin
      e.uid = uid[UID_W-1:0];
      e.bus = pay[BUS_W-1:0];
      exp_q.push_back(e);
    end
    send_byte(uid[15:8], rnd);
    send_byte(uid[7:0], rnd);
    for (int k = 10; k >= 0; k--) send_byte(pay[k*8 +: 8], rnd);
  endtask

  task automatic wait_pulses(input int n);
    int g;
    g = 0;
    while (pulses < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (pulses < n) chk("pulse_wait", pulses, n);
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (dones < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (dones < n) chk("done_wait", dones, n);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pays[0]  = '1;
    for (int i = 1; i < NUM_FRAMES; i++) pays[i] = {24'($urandom), $urandom, $urandom};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode, 0);
    chk("rst_c_clk", c_clk, 0);
    chk("rst_c_bus", c_bus, 0);
    chk("rst_c_uid", c_uid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // in_valid while idle must not consume anything
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
    end
    chk("idle_busy", busy, 0);

    // Load A: back-to-back, single-frame checks, bad uid, start while busy
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_mode", mode, 1);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_err", err, 0);
    send_frame(frame_uid(0), pays[0], 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_pulses(1);
    chk("first_c_uid", c_uid, 9'h005);
    chk("first_c_bus", c_bus, 82'h3FFFF_FFFFFFFF_FFFFFFFF);
    chk("err_before_bad", err, 0);
    send_frame(16'h00C8, {24'($urandom), $urandom, $urandom}, 1'b0, 1'b0);
    chk("err_after_bad", err, 1);
    chk("bad_back_to_hdr", in_ready, 1);
    for (int i = 1; i < NUM_FRAMES; i++) begin
      if (i == 50) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == 60) chk("err_sticky_in_load", err, 1);
      send_frame(frame_uid(i), pays[i], 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    wait_done(1);
    chk("loadA_pulses", pulses, 100);
    chk("loadA_dones", dones, 1);
    chk("loadA_mode", mode, 0);
    chk("loadA_busy", busy, 0);
    chk("loadA_err_sticky", err, 1);
    chk("loadA_queue_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("loadA_done_once", dones, 1);

    // Load B: same frames with random in_valid gaps
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("loadB_err_cleared", err, 0);
    chk("loadB_mode", mode, 1);
    for (int i = 0; i < NUM_FRAMES; i++) begin
      send_frame((i == 0) ? 16'hFE05 : frame_uid(i), pays[i], 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    wait_done(2);
    chk("loadB_pulses", pulses, 200);
    chk("loadB_dones", dones, 2);
    chk("loadB_queue_empty", exp_q.size(), 0);
    chk("loadB_err", err, 0);

    // Load C: reset after the 7th payload byte
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    for (int k = 0; k < 7; k++) send_byte(8'h30 + 8'(k), 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_c_clk", c_clk, 0);
    chk("mid_rst_c_bus", c_bus, 0);
    chk("mid_rst_c_uid", c_uid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("post_rst_no_strobe", pulses, 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter BUS_W, default 82, configuration word width driven on c_bus.
REQ-002 Parameter UID_W, default 9, target cell identifier width driven on c_uid.
REQ-003 Parameter NUM_FRAMES, default 100, frames per complete load (10x10 fabric).
REQ-004 Parameter CCLK_HALF, default 2, clk cycles per c_clk half-period (>=1).
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load.
REQ-008 in_data  input  8  configuration byte stream.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 mode  output  1  fabric configuration mode; 1 = configuring, 0 = run.
REQ-012 c_bus  output  BUS_W  configuration word to fabric.
REQ-013 c_uid  output  UID_W  target cell identifier.
REQ-014 c_clk  output  1  configuration strobe clock to fabric.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse when the last frame is strobed.
REQ-017 err  output  1  sticky: frame with uid >= NUM_FRAMES received.

Function
REQ-018 FSM states: IDLE, HDR, PAYLOAD, SETUP, CLK_HI, CLK_LO.
REQ-019 IDLE: in_ready=0, busy=0, mode=0; start -> HDR, mode=1, frame counter=0, err cleared.
REQ-020 Byte transfer occurs only when in_valid && in_ready; in_ready=1 only in HDR and PAYLOAD.
REQ-021 Frame = 2 header bytes + ceil(BUS_W/8)=11 payload bytes, big-endian, MSB first.
REQ-022 Header: uid = {byte0, byte1}[UID_W-1:0]; upper unused bits ignored; after byte1 -> PAYLOAD.
REQ-023 Payload: shifted into an 88-bit register; c_bus takes the low BUS_W bits; after byte 11 -> SETUP.
REQ-024 c_bus/c_uid update only on entry to SETUP and hold stable through SETUP, CLK_HI, CLK_LO.
REQ-025 SETUP lasts 1 cycle, c_clk=0; CLK_HI holds c_clk=1 for CCLK_HALF cycles; CLK_LO holds c_clk=0 for CCLK_HALF cycles.
REQ-026 c_clk is a registered output, glitch-free.
REQ-027 Frame with uid >= NUM_FRAMES: err set, no SETUP/strobe, not counted, return to HDR.
REQ-028 Frame counter increments at end of CLK_LO; if it reaches NUM_FRAMES: done pulse, mode=0, -> IDLE; else -> HDR.
REQ-029 Latency: last payload byte accepted in cycle N -> c_clk rises in cycle N+2.
REQ-030 start while busy is ignored; in_valid in IDLE is ignored (no byte consumed).
REQ-031 in_valid deasserted mid-frame stalls the FSM indefinitely, with no timeout and no state loss.
REQ-032 mode stays 1 from start acceptance until the cycle done pulses.

Reset
REQ-033 rst asynchronously forces IDLE, counters 0, mode=0, c_clk=0, c_bus=0, c_uid=0, in_ready=0, busy=0, done=0, err=0.
REQ-034 rst mid-load abandons the partial frame; no strobe is issued after reset deassertion.

Structure
REQ-035 Shared package novacore_cfg_pkg holds the FSM state enum, BUS_W/UID_W defaults and the header/payload byte-count constants.
REQ-036 One sub-module cfg_frame_assembler (byte shifter plus header/payload byte counter); the FSM and strobe timing stay in config_loader.

Verification
REQ-037 Start, one frame uid=0x005, payload all 0xFF -> c_uid=5, c_bus=82'h3FFFF_FFFFFFFF_FFFFFFFF, one c_clk pulse 2 cycles high, rising at N+2.
REQ-038 Full load of 100 frames, uid 0..99, in_valid held high -> exactly 100 c_clk pulses, done once, mode falls in the done cycle.
REQ-039 Frame uid=0x0C8 (200) -> err=1, no c_clk pulse, next valid frame strobes normally, err stays 1 until the next start.
REQ-040 in_valid toggled randomly 50% -> same c_bus/c_uid sequence as the back-to-back case; c_bus never changes while c_clk=1.
REQ-041 rst asserted after the 7th payload byte -> all outputs 0 immediately; after release, in_ready=0 until start.
REQ-042 start pulsed during the load and in_valid asserted in IDLE -> no effect on the frame count or consumed bytes.
